// File: rtl/fx_bus_pkg.sv
// Shared definitions for the 68000 bus responder: state encoding, region select and defaults.
package fx_bus_pkg;

    // Responder states; the encoding is fixed so the state can be probed by number.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ROM  = 3'd2,
        ST_ACK  = 3'd3,
        ST_BERR = 3'd4
    } bus_state_t;

    // Region chosen at cycle start after priority resolution.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_IO   = 2'd1,
        SEL_BRAM = 2'd2,
        SEL_ROM  = 2'd3
    } bus_sel_t;

    localparam int unsigned BRAM_WAIT_DEF   = 1;
    localparam int unsigned IO_WAIT_DEF     = 0;
    localparam int unsigned ROM_TIMEOUT_DEF = 255;
    localparam int unsigned ADDR_W_DEF      = 23;

    // Counter wide enough for the largest ROM timeout (1023).
    localparam int unsigned CNT_W = 10;

    // Resolve overlapping selects: ROM beats BRAM beats I/O; a decoder fault is not flagged.
    function automatic bus_sel_t select_region(input logic rom_cs,
                                               input logic bram_cs,
                                               input logic io_cs);
        bus_sel_t sel;
        if (rom_cs) begin
            sel = SEL_ROM;
        end else if (bram_cs) begin
            sel = SEL_BRAM;
        end else if (io_cs) begin
            sel = SEL_IO;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Loadable down-counter with a zero flag, shared by wait states and the ROM timeout.
module bus_wait_counter #(
    parameter int unsigned W = 10
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero_c
);

    // Load has priority over decrement; decrement saturates at zero.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/m68k_bus_responder.sv
// Terminates 68000 bus cycles with DTACK_n (or BERR_n on a stalled ROM fetch),
// forwarding ROM cycles to the SDRAM controller over a req/ack handshake.
module m68k_bus_responder
    import fx_bus_pkg::*;
#(
    parameter int unsigned BRAM_WAIT   = BRAM_WAIT_DEF,
    parameter int unsigned IO_WAIT     = IO_WAIT_DEF,
    parameter int unsigned ROM_TIMEOUT = ROM_TIMEOUT_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m68k_a,
    input  logic              m68k_as_n,
    input  logic              m68k_rw,
    input  logic              rom_cs,
    input  logic              bram_cs,
    input  logic              io_cs,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    output logic              m68k_dtack_n,
    output logic              m68k_berr_n,
    output logic              busy
);

    localparam logic [CNT_W-1:0] BRAM_LOAD = CNT_W'(BRAM_WAIT);
    localparam logic [CNT_W-1:0] IO_LOAD   = CNT_W'(IO_WAIT);
    localparam logic [CNT_W-1:0] ROM_LOAD  = CNT_W'(ROM_TIMEOUT);

    bus_state_t       state_q;
    bus_state_t       state_d;
    bus_sel_t         sel_c;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_zero_c;
    logic             addr_latch;
    logic             dtack_n_d;
    logic             berr_n_d;

    // Direction does not affect termination; reads and writes complete identically.
    logic unused_rw;
    assign unused_rw = m68k_rw;

    assign sel_c = select_region(rom_cs, bram_cs, io_cs);

    // One counter serves as the wait-state timer and the ROM timeout.
    bus_wait_counter #(
        .W (CNT_W)
    ) u_wait_counter (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_q),
        .zero_c   (cnt_zero_c)
    );

    // State register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, counter control and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        addr_latch   = 1'b0;
        dtack_n_d    = 1'b1;
        berr_n_d     = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (!m68k_as_n) begin
                    addr_latch = 1'b1;
                    case (sel_c)
                        SEL_ROM: begin
                            cnt_load     = 1'b1;
                            cnt_load_val = ROM_LOAD;
                            state_d      = ST_ROM;
                        end
                        SEL_BRAM: begin
                            cnt_load     = 1'b1;
                            cnt_load_val = BRAM_LOAD;
                            state_d      = (BRAM_LOAD == '0) ? ST_ACK : ST_WAIT;
                        end
                        SEL_IO: begin
                            cnt_load     = 1'b1;
                            cnt_load_val = IO_LOAD;
                            state_d      = (IO_LOAD == '0) ? ST_ACK : ST_WAIT;
                        end
                        default: begin
                            // Unmapped: acknowledge anyway so the CPU never hangs.
                            state_d = ST_ACK;
                        end
                    endcase
                end
            end

            ST_WAIT: begin
                if (m68k_as_n) begin
                    state_d = ST_IDLE;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            ST_ROM: begin
                // Abort first, then ack; ack beats a timeout expiring on the same edge.
                if (m68k_as_n) begin
                    state_d = ST_IDLE;
                end else if (rom_ack) begin
                    state_d = ST_ACK;
                end else if (cnt_zero_c) begin
                    state_d = ST_BERR;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            ST_ACK: begin
                if (m68k_as_n) begin
                    state_d = ST_IDLE;
                end else begin
                    dtack_n_d = 1'b0;
                end
            end

            ST_BERR: begin
                if (m68k_as_n) begin
                    state_d = ST_IDLE;
                end else begin
                    berr_n_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs; rom_req and busy track the state being entered.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            m68k_dtack_n <= 1'b1;
            m68k_berr_n  <= 1'b1;
            rom_req      <= 1'b0;
            busy         <= 1'b0;
            rom_addr     <= '0;
        end else begin
            m68k_dtack_n <= dtack_n_d;
            m68k_berr_n  <= berr_n_d;
            rom_req      <= (state_d == ST_ROM);
            busy         <= (state_d != ST_IDLE);
            if (addr_latch) begin
                rom_addr <= m68k_a;
            end
        end
    end

endmodule
